// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM port controllers and the arbiter feeding them:
// default widths, reader tags, delay-line entry layout and the address range guard.
package bram_pkg;

  localparam int BRAM_ADDR_W = 13;
  localparam int BRAM_DATA_W = 32;

  localparam logic READER_DMA = 1'b0;
  localparam logic READER_CPU = 1'b1;

  typedef struct packed {
    logic                   valid;
    logic                   sel;
    logic [BRAM_DATA_W-1:0] data;
  } rd_entry_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/bram_sp_array.sv
// Single-port storage: synchronous write, registered read, out-of-range guard.
// No reset on contents so a vendor macro can replace it one-for-one.
module bram_sp_array
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DEPTH  = 8192
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = addr_in_range(32'(i_addr), DEPTH);
  assign w_idx      = IDX_W'(i_addr);

  // Write port: out-of-range writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_we && w_in_range) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  // Read port: out-of-range reads return zero.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= w_in_range ? r_mem[w_idx] : {DATA_W{1'b0}};
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_ctrl.sv
// Pipelined single-port BRAM controller: one request per cycle, writes commit at once,
// reads return after DELAYS cycles steered to the DMA or CPU path by their tag.
module bram_ctrl
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DEPTH  = 8192,
  parameter int DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_sel,
  output logic              dma_rd_valid,
  output logic [DATA_W-1:0] dma_rd_data,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [3:0]        rd_pending,
  output logic              addr_err
);

  logic              w_in_range;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rdata;
  rd_entry_t         w_head;
  rd_entry_t         w_tail;
  logic              w_dma_hit;
  logic              w_cpu_hit;

  logic              r_head_valid;
  logic              r_head_sel;
  logic [DATA_W-1:0] r_dma_hold;
  logic [DATA_W-1:0] r_cpu_hold;
  logic [3:0]        r_pending;
  logic              r_addr_err;

  assign w_in_range = addr_in_range(32'(req_addr), DEPTH);
  assign w_rd_acc   = req_valid & ~req_wr & ~wb_rst_i;
  assign w_wr_acc   = req_valid &  req_wr & ~wb_rst_i;

  bram_sp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (wb_clk_i),
    .i_we    (w_wr_acc),
    .i_re    (w_rd_acc),
    .i_addr  (req_addr),
    .i_wdata (req_data),
    .o_rdata (w_rdata)
  );

  // The array's read register is stage one; its tag rides alongside here.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_head_valid <= 1'b0;
      r_head_sel   <= READER_DMA;
    end else begin
      r_head_valid <= w_rd_acc;
      r_head_sel   <= req_sel;
    end
  end

  assign w_head = {r_head_valid, r_head_sel, w_rdata};

  generate
    if (DELAYS == 1) begin : g_no_pipe
      assign w_tail = w_head;
    end else begin : g_pipe
      rd_entry_t r_pipe [DELAYS-1];

      // Remaining DELAYS-1 stages of the read delay line.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          for (int i = 0; i < DELAYS - 1; i++) begin
            r_pipe[i] <= '0;
          end
        end else begin
          r_pipe[0] <= w_head;
          for (int i = 1; i < DELAYS - 1; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_tail = r_pipe[DELAYS-2];
    end
  endgenerate

  assign w_dma_hit = w_tail.valid & (w_tail.sel == READER_DMA);
  assign w_cpu_hit = w_tail.valid & (w_tail.sel == READER_CPU);

  // Each bus keeps its last returned word until its own next pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_dma_hold <= {DATA_W{1'b0}};
      r_cpu_hold <= {DATA_W{1'b0}};
    end else begin
      if (w_dma_hit) begin
        r_dma_hold <= w_tail.data;
      end
      if (w_cpu_hit) begin
        r_cpu_hold <= w_tail.data;
      end
    end
  end

  // Outstanding reads: +1 per read accept, -1 per return pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pending <= 4'd0;
    end else begin
      case ({w_rd_acc, w_tail.valid})
        2'b10:   r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_addr_err <= 1'b0;
    end else if (req_valid && !w_in_range) begin
      r_addr_err <= 1'b1;
    end
  end

  assign dma_rd_valid = w_dma_hit;
  assign cpu_rd_valid = w_cpu_hit;
  assign dma_rd_data  = w_dma_hit ? w_tail.data : r_dma_hold;
  assign cpu_rd_data  = w_cpu_hit ? w_tail.data : r_cpu_hold;
  assign rd_pending   = r_pending;
  assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_bram_ctrl.sv
// Bench for bram_ctrl: a DELAYS=10 / DEPTH=8192 instance (u0) and a DELAYS=1 / DEPTH=12
// instance (u1), checked every cycle against a return-schedule model plus literal checks.
module tb_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv   [2];
  logic        rw   [2];
  logic        rs   [2];
  logic [13:0] ra   [2];
  logic [31:0] rdat [2];
  logic        dv   [2];
  logic        cv   [2];
  logic [31:0] dd   [2];
  logic [31:0] cd   [2];
  logic [3:0]  pn   [2];
  logic        er   [2];

  int n_pass  = 0;
  int n_total = 0;

  bram_ctrl #(.ADDR_W(14), .DATA_W(32), .DEPTH(8192), .DELAYS(10)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(rv[0]), .req_wr(rw[0]), .req_addr(ra[0]), .req_data(rdat[0]), .req_sel(rs[0]),
    .dma_rd_valid(dv[0]), .dma_rd_data(dd[0]), .cpu_rd_valid(cv[0]), .cpu_rd_data(cd[0]),
    .rd_pending(pn[0]), .addr_err(er[0])
  );

  bram_ctrl #(.ADDR_W(4), .DATA_W(32), .DEPTH(12), .DELAYS(1)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(rv[1]), .req_wr(rw[1]), .req_addr(ra[1][3:0]), .req_data(rdat[1]), .req_sel(rs[1]),
    .dma_rd_valid(dv[1]), .dma_rd_data(dd[1]), .cpu_rd_valid(cv[1]), .cpu_rd_data(cd[1]),
    .rd_pending(pn[1]), .addr_err(er[1])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, got, exp);
  endtask

  // Model: per-cycle return schedule, memory image, pending count, sticky error.
  function automatic int lat_of(input int d);
    return (d == 0) ? 10 : 1;
  endfunction
  function automatic int dep_of(input int d);
    return (d == 0) ? 8192 : 12;
  endfunction

  bit        m_v    [2][4096];
  bit        m_s    [2][4096];
  bit [31:0] m_d    [2][4096];
  bit [31:0] m_mem  [2][8192];
  bit [31:0] m_hdma [2];
  bit [31:0] m_hcpu [2];
  int        m_pend [2];
  bit        m_err  [2];
  int        ecnt = 0;

  // Edge update: returns that just ended leave the pending count, new requests enter.
  initial begin : model_edge
    int a;
    int due;
    bit inr;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) if (!rst && m_v[d][ecnt]) m_pend[d]--;
      ecnt++;
      for (int d = 0; d < 2; d++) begin
        if (!rst && rv[d]) begin
          a   = (d == 0) ? int'(ra[0]) : int'(ra[1][3:0]);
          inr = (a < dep_of(d));
          if (!inr) m_err[d] = 1'b1;
          if (rw[d]) begin
            if (inr) m_mem[d][a] = rdat[d];
          end else begin
            due         = ecnt + lat_of(d) - 1;
            m_v[d][due] = 1'b1;
            m_s[d][due] = rs[d];
            m_d[d][due] = inr ? m_mem[d][a] : 32'h0;
            m_pend[d]++;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin : compare
    bit        edv, ecv;
    bit [31:0] edd, ecd;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int j = 0; j < 4096; j++) m_v[d][j] = 1'b0;
          m_hdma[d] = 32'h0;
          m_hcpu[d] = 32'h0;
          m_pend[d] = 0;
          m_err[d]  = 1'b0;
        end
        edv = m_v[d][ecnt] && !m_s[d][ecnt];
        ecv = m_v[d][ecnt] &&  m_s[d][ecnt];
        edd = edv ? m_d[d][ecnt] : m_hdma[d];
        ecd = ecv ? m_d[d][ecnt] : m_hcpu[d];
        chk($sformatf("u%0d dma_rd_valid cyc%0d", d, ecnt), 32'(dv[d]), 32'(edv));
        chk($sformatf("u%0d cpu_rd_valid cyc%0d", d, ecnt), 32'(cv[d]), 32'(ecv));
        chk($sformatf("u%0d dma_rd_data cyc%0d", d, ecnt), dd[d], edd);
        chk($sformatf("u%0d cpu_rd_data cyc%0d", d, ecnt), cd[d], ecd);
        chk($sformatf("u%0d rd_pending cyc%0d", d, ecnt), 32'(pn[d]), 32'(m_pend[d]));
        chk($sformatf("u%0d addr_err cyc%0d", d, ecnt), 32'(er[d]), 32'(m_err[d]));
        m_hdma[d] = edd;
        m_hcpu[d] = ecd;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input int d, input bit wr, input int addr, input int data, input bit sel);
    rv[d]   = 1'b1;
    rw[d]   = wr;
    ra[d]   = 14'(addr);
    rdat[d] = 32'(data);
    rs[d]   = sel;
    tick(1);
    rv[d]   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary, required completion");
    $fatal(1);
  end

  initial begin : stim
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; rs[d] = 1'b0; ra[d] = 14'd0; rdat[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("reset dma_rd_valid", 32'(dv[0]), 32'd0);
    chk("reset cpu_rd_data", cd[0], 32'd0);
    chk("reset rd_pending", 32'(pn[0]), 32'd0);
    chk("reset addr_err", 32'(er[0]), 32'd0);

    // Write then read-after-write to CPU
    req(0, 1'b1, 5, 32'hDEADBEEF, 1'b0);
    req(0, 1'b0, 5, 0, 1'b1);
    tick(9);
    chk("raw cpu_rd_valid", 32'(cv[0]), 32'd1);
    chk("raw cpu_rd_data", cd[0], 32'hDEADBEEF);
    chk("raw dma_rd_valid", 32'(dv[0]), 32'd0);
    tick(3);

    // Eight back-to-back reads with alternating destination
    for (int i = 0; i < 8; i++) req(0, 1'b1, i, 32'h100 + i, 1'b0);
    for (int i = 0; i < 8; i++) req(0, 1'b0, i, 0, 1'(i % 2));
    chk("burst rd_pending full", 32'(pn[0]), 32'd8);
    tick(2);
    chk("burst first dma_rd_valid", 32'(dv[0]), 32'd1);
    chk("burst first dma_rd_data", dd[0], 32'h100);
    tick(1);
    chk("burst second cpu_rd_data", cd[0], 32'h101);
    tick(20);
    chk("burst rd_pending drained", 32'(pn[0]), 32'd0);
    chk("burst last dma hold", dd[0], 32'h106);
    chk("burst last cpu hold", cd[0], 32'h107);

    // Top-of-range and out-of-range reads
    req(0, 1'b1, 8191, 32'hCAFE0001, 1'b0);
    req(0, 1'b0, 8191, 0, 1'b0);
    chk("edge addr_err before", 32'(er[0]), 32'd0);
    req(0, 1'b0, 8192, 0, 1'b1);
    chk("oor addr_err rises", 32'(er[0]), 32'd1);
    tick(12);
    chk("oor addr_err sticky", 32'(er[0]), 32'd1);
    chk("edge 8191 data", dd[0], 32'hCAFE0001);
    chk("oor read data", cd[0], 32'h0);

    // Dropped out-of-range write, reads in flight, then reset
    req(0, 1'b1, 9, 32'h5A5A0009, 1'b0);
    req(0, 1'b1, 8192, 32'h0BAD0BAD, 1'b0);
    req(0, 1'b0, 0, 0, 1'b0);
    req(0, 1'b0, 1, 0, 1'b1);
    req(0, 1'b0, 2, 0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst rd_pending", 32'(pn[0]), 32'd0);
    chk("rst addr_err", 32'(er[0]), 32'd0);
    tick(12);
    chk("rst no late returns", 32'(pn[0]), 32'd0);
    req(0, 1'b0, 9, 0, 1'b1);
    req(0, 1'b0, 0, 0, 1'b0);
    tick(8);
    chk("post-rst cpu_rd_valid", 32'(cv[0]), 32'd1);
    chk("post-rst cpu_rd_data", cd[0], 32'h5A5A0009);
    tick(1);
    chk("dropped write kept addr0", dd[0], 32'h100);
    tick(3);

    // DELAYS=1 instance: alternating write/read to the same address
    for (int i = 0; i < 8; i++) begin
      req(1, 1'b1, 3, i, 1'b0);
      req(1, 1'b0, 3, 0, 1'(i % 2));
      if (i % 2 == 1) begin
        chk($sformatf("d1 cpu_rd_valid i%0d", i), 32'(cv[1]), 32'd1);
        chk($sformatf("d1 cpu_rd_data i%0d", i), cd[1], 32'(i));
      end else begin
        chk($sformatf("d1 dma_rd_valid i%0d", i), 32'(dv[1]), 32'd1);
        chk($sformatf("d1 dma_rd_data i%0d", i), dd[1], 32'(i));
      end
    end
    req(1, 1'b0, 13, 0, 1'b0);
    chk("d1 oor dma_rd_valid", 32'(dv[1]), 32'd1);
    chk("d1 oor dma_rd_data", dd[1], 32'h0);
    chk("d1 oor addr_err", 32'(er[1]), 32'd1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
